// File: rtl/fp_pkg.sv
// Shared definitions for the float <-> Q8.8 fixed-point converters:
// FSM state encoding, binary16 field limits and Q8.8 saturation values.
package fp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_CLASS,
      S_SHIFT,
      S_ROUND,
      S_WR_LO,
      S_WR_HI
   } state_t;

   localparam logic [4:0]  FP16_BIAS    = 5'd15;
   localparam logic [4:0]  FP16_EXP_MAX = 5'd31;
   localparam logic [15:0] Q88_POS_SAT  = 16'h7FFF;
   localparam logic [15:0] Q88_NEG_SAT  = 16'h8000;
   localparam logic [4:0]  Q88_EXP_SAT  = 5'd22;
   localparam logic [4:0]  Q88_EXP_ZERO = 5'd5;

   // Exponent at which {1,m} already sits at the Q8.8 binary point (no shift).
   localparam logic [4:0]  Q88_EXP_POINT = FP16_BIAS + 5'd2;

   function automatic logic [15:0] sat_by_sign(input logic sign);
      return sign ? Q88_NEG_SAT : Q88_POS_SAT;
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on an unsigned magnitude with guard/sticky bits,
// then apply the sign to give a 16-bit two's-complement result.
module fp_round_rne (
   input  logic [15:0] i_mag,
   input  logic        i_guard,
   input  logic        i_sticky,
   input  logic        i_sign,
   output logic [15:0] o_result
);

   logic        w_round_up;
   logic [15:0] w_mag_rnd;

   // Ties (guard set, sticky clear) round up only when the kept LSB is odd.
   assign w_round_up = i_guard & (i_sticky | i_mag[0]);
   assign w_mag_rnd  = i_mag + {15'd0, w_round_up};
   assign o_result   = i_sign ? (~w_mag_rnd + 16'd1) : w_mag_rnd;

endmodule

// File: rtl/flt2fix.sv
// Iterative binary16 -> Q8.8 converter: reads two bytes from data memory,
// shifts the significand one bit per cycle, rounds and writes two bytes back.
module flt2fix
   import fp_pkg::*;
#(
   parameter int AW       = 8,
   parameter int IN_ADDR  = 0,
   parameter int OUT_ADDR = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   state_t      r_state, w_next;
   logic [7:0]  r_flt_lo, r_flt_hi;
   logic [15:0] r_mag, r_force_val, r_result;
   logic        r_guard, r_sticky, r_left, r_force, r_done;
   logic [3:0]  r_cnt;

   logic        w_sign;
   logic [4:0]  w_exp;
   logic [9:0]  w_man;
   logic [3:0]  w_k;
   logic        w_left, w_force;
   logic [15:0] w_force_val, w_rounded;

   assign {w_sign, w_exp, w_man} = {r_flt_hi, r_flt_lo};
   assign done = r_done;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_k         = '0;
      w_left      = 1'b0;
      w_force     = 1'b1;
      w_force_val = '0;
      // Exponents up to Q88_EXP_ZERO (incl. zero/subnormal) stay below half an LSB.
      if (w_exp > Q88_EXP_ZERO) begin
         if (w_exp == FP16_EXP_MAX) begin
            w_force_val = (w_man != '0) ? Q88_POS_SAT : sat_by_sign(w_sign);
         end else if (w_exp >= Q88_EXP_SAT) begin
            w_force_val = sat_by_sign(w_sign);
         end else if (w_exp >= Q88_EXP_POINT) begin
            w_force = 1'b0;
            w_left  = 1'b1;
            w_k     = 4'(w_exp - Q88_EXP_POINT);
         end else begin
            w_force = 1'b0;
            w_k     = 4'(Q88_EXP_POINT - w_exp);
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_addr  = '0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RD_LO;
         S_RD_LO: begin
            mem_addr = AW'(IN_ADDR);
            w_next   = S_RD_HI;
         end
         S_RD_HI: begin
            mem_addr = AW'(IN_ADDR + 1);
            w_next   = S_CLASS;
         end
         S_CLASS: w_next = (w_k == '0) ? S_ROUND : S_SHIFT;
         S_SHIFT: if (r_cnt == 4'd1) w_next = S_ROUND;
         S_ROUND: w_next = S_WR_LO;
         S_WR_LO: begin
            mem_addr  = AW'(OUT_ADDR);
            mem_wr_en = 1'b1;
            mem_wdata = r_result[7:0];
            w_next    = S_WR_HI;
         end
         S_WR_HI: begin
            mem_addr  = AW'(OUT_ADDR + 1);
            mem_wr_en = 1'b1;
            mem_wdata = r_result[15:8];
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_flt_lo    <= '0;
         r_flt_hi    <= '0;
         r_mag       <= '0;
         r_guard     <= 1'b0;
         r_sticky    <= 1'b0;
         r_left      <= 1'b0;
         r_force     <= 1'b0;
         r_force_val <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:  if (start) r_done <= 1'b0;
            S_RD_LO: r_flt_lo <= mem_rdata;
            S_RD_HI: r_flt_hi <= mem_rdata;
            S_CLASS: begin
               r_mag       <= {5'd0, 1'b1, w_man};
               r_guard     <= 1'b0;
               r_sticky    <= 1'b0;
               r_left      <= w_left;
               r_force     <= w_force;
               r_force_val <= w_force_val;
               r_cnt       <= w_k;
            end
            S_SHIFT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_left) begin
                  r_mag <= {r_mag[14:0], 1'b0};
               end else begin
                  // Bits leaving the LSB pass through guard, then accumulate in sticky.
                  r_mag    <= {1'b0, r_mag[15:1]};
                  r_guard  <= r_mag[0];
                  r_sticky <= r_sticky | r_guard;
               end
            end
            S_ROUND: r_result <= r_force ? r_force_val : w_rounded;
            S_WR_HI: r_done   <= 1'b1;
            default: ;
         endcase
      end
   end

   fp_round_rne u_round (
      .i_mag    (r_mag),
      .i_guard  (r_guard),
      .i_sticky (r_sticky),
      .i_sign   (w_sign),
      .o_result (w_rounded)
   );

endmodule

// File: tb/tb_flt2fix.sv
// Directed bench for flt2fix: a byte-addressed memory model, a scoreboard of
// expected Q8.8 results and latency/write-pattern checks per conversion.
module tb_flt2fix;

   localparam int AW       = 8;
   localparam int IN_ADDR  = 0;
   localparam int OUT_ADDR = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic          mem_wr_en;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   logic [7:0]    in_lo = 8'h00;
   logic [7:0]    in_hi = 8'h00;

   int            wr_count = 0;
   logic [7:0]    wr_addr_log [0:255];
   logic [7:0]    wr_data_log [0:255];

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [15:0]   sb [$];

   flt2fix #(.AW(AW), .IN_ADDR(IN_ADDR), .OUT_ADDR(OUT_ADDR)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr == AW'(IN_ADDR))     ? in_lo :
                      (mem_addr == AW'(IN_ADDR + 1)) ? in_hi : 8'h00;

   always @(posedge clk) begin
      if (mem_wr_en) begin
         wr_addr_log[wr_count[7:0]] <= mem_addr;
         wr_data_log[wr_count[7:0]] <= mem_wdata;
         wr_count                   <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Starts a conversion on the current negedge; expects done in cycle 7+k.
   task automatic run_conv(input logic [15:0] flt, input logic [15:0] exp_res,
                           input int k, input bit busy_pulse);
      int          base;
      int          lat;
      logic [15:0] want;
      in_lo = flt[7:0];
      in_hi = flt[15:8];
      sb.push_back(exp_res);
      base  = wr_count;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("done_cleared_%h", flt), {31'd0, done}, 32'd0);
      lat = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (busy_pulse && cyc == 3) start = 1'b1;
         if (busy_pulse && cyc == 4) start = 1'b0;
         if (done) begin
            lat = cyc;
            break;
         end
      end
      start = 1'b0;
      check($sformatf("latency_%h", flt), lat, 7 + k);
      want = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      check($sformatf("result_%h", flt),
            {16'd0, wr_data_log[(base + 1) % 256], wr_data_log[base % 256]}, {16'd0, want});
      check($sformatf("nwrites_%h", flt), wr_count - base, 2);
      check($sformatf("wr_addrs_%h", flt),
            {16'd0, wr_addr_log[base % 256], wr_addr_log[(base + 1) % 256]},
            {16'd0, 8'(OUT_ADDR), 8'(OUT_ADDR + 1)});
   endtask

   initial begin
      int base;
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_done",  {31'd0, done},      32'd0);
      check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("rst_addr",  {24'd0, mem_addr},  32'd0);
      check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Conversions run back to back: each starts on the negedge done is seen.
      run_conv(16'h3C00, 16'h0100, 2,  1'b0);
      run_conv(16'hC500, 16'hFB00, 0,  1'b0);
      run_conv(16'h57FF, 16'h7FF0, 4,  1'b0);
      run_conv(16'h1C00, 16'h0001, 10, 1'b0);
      run_conv(16'h1800, 16'h0000, 11, 1'b0);
      run_conv(16'h1E00, 16'h0002, 10, 1'b0);
      run_conv(16'h1A00, 16'h0001, 11, 1'b0);
      run_conv(16'h5800, 16'h7FFF, 0,  1'b0);
      run_conv(16'hD800, 16'h8000, 0,  1'b0);
      run_conv(16'h7C00, 16'h7FFF, 0,  1'b0);
      run_conv(16'hFC00, 16'h8000, 0,  1'b0);
      run_conv(16'h7E00, 16'h7FFF, 0,  1'b0);
      run_conv(16'h8000, 16'h0000, 0,  1'b0);
      run_conv(16'h03FF, 16'h0000, 0,  1'b0);
      run_conv(16'h1400, 16'h0000, 0,  1'b0);
      run_conv(16'h4248, 16'h0324, 1,  1'b0);
      run_conv(16'hBC00, 16'hFF00, 2,  1'b0);
      run_conv(16'h2E66, 16'h001A, 6,  1'b0);
      run_conv(16'h3C00, 16'h0100, 2,  1'b1);

      // Reset during SHIFT of a 1.0 conversion.
      in_lo = 8'h00;
      in_hi = 8'h3C;
      base  = wr_count;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_done",  {31'd0, done},      32'd0);
      check("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("midrst_addr",  {24'd0, mem_addr},  32'd0);
      repeat (15) @(negedge clk);
      check("midrst_nowrite", wr_count - base, 0);
      check("midrst_idle_done", {31'd0, done}, 32'd0);

      // Reset and start together: reset wins, nothing starts.
      start = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("rst_vs_start_nowrite", wr_count - base, 0);
      check("rst_vs_start_done", {31'd0, done}, 32'd0);

      run_conv(16'h3C00, 16'h0100, 2, 1'b0);
      run_conv(16'hC500, 16'hFB00, 0, 1'b0);
      check("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
